// File: rtl/mem_responder_if.sv
// Memory-side bus between the CPU control FSM and the memory responder.
// The CPU (master) raises one strobe and holds it, together with Address and
// WriteData, until MemReady; the responder (slave) answers with a one-cycle
// MemReady, MemBusy while the access is pending, and a one-cycle AddrError
// for a rejected request.
interface mem_responder_if;

  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        MemReady;
  logic        MemBusy;
  logic        AddrError;

  // CPU side: drives strobes, address and store data.
  modport master (
    output MemRead,
    output MemWrite,
    output Address,
    output WriteData,
    input  ReadData,
    input  MemReady,
    input  MemBusy,
    input  AddrError
  );

  // Memory side: answers with load data and status.
  modport slave (
    input  MemRead,
    input  MemWrite,
    input  Address,
    input  WriteData,
    output ReadData,
    output MemReady,
    output MemBusy,
    output AddrError
  );

endinterface

// File: rtl/mem_responder.sv
// Word-addressed data/instruction memory responder for the multicycle CPU.
//
// A request is accepted in IDLE when exactly one strobe is high and the byte
// address is word aligned and inside the 2^ADDR_WIDTH-word array. The address,
// store data and operation are latched, so the CPU may change its bus during
// the access without effect. The FSM then sits in WAIT for LATENCY+1 cycles;
// on the edge that leaves WAIT the array is written or ReadData is loaded, and
// RESP raises MemReady for one cycle. Strobes are not sampled in RESP, so the
// shortest spacing between accepts is LATENCY+3 cycles.
//
// Rejected requests (bad alignment, address beyond the array, or both strobes
// at once) never touch the array; they produce a one-cycle AddrError that
// repeats every cycle for as long as the CPU keeps the bad request up.
module mem_responder #(
  parameter int ADDR_WIDTH = 8,
  parameter int LATENCY    = 2
) (
  input  logic           Clock,
  input  logic           Reset,
  mem_responder_if.slave bus
);

  localparam int         DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // ---------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------
  state_t                  state_reg;
  state_t                  state_next;
  logic [3:0]              count_reg;
  logic [3:0]              count_next;
  logic                    addr_error_reg;
  logic [ADDR_WIDTH-1:0]   word_addr_reg;
  logic [31:0]             wdata_reg;
  logic                    op_write_reg;
  logic [31:0]             rdata_reg;

  // Storage; intentionally never cleared so it maps onto block RAM.
  logic [31:0]             mem_array [0:DEPTH-1];

  // ---------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------
  logic                    req_any;
  logic                    req_one;
  logic                    addr_aligned;
  logic                    addr_in_range;
  logic                    addr_ok;

  // Decode the incoming strobes and qualify the byte address.
  always_comb begin
    req_any       = bus.MemRead | bus.MemWrite;
    req_one       = bus.MemRead ^ bus.MemWrite;
    addr_aligned  = (bus.Address[1:0] == 2'b00);
    // Any set bit above the array index is out of range; there is no aliasing.
    addr_in_range = (bus.Address[31:ADDR_WIDTH+2] == '0);
    addr_ok       = addr_aligned & addr_in_range;
  end

  // ---------------------------------------------------------------------
  // Control FSM: next-state and strobes for the datapath
  // ---------------------------------------------------------------------
  logic                    accept;
  logic                    reject;
  logic                    mem_we;
  logic                    mem_re;

  // Next state, wait counter and per-cycle datapath enables.
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    accept     = 1'b0;
    reject     = 1'b0;
    mem_we     = 1'b0;
    mem_re     = 1'b0;

    unique case (state_reg)
      ST_IDLE: begin
        if (req_one && addr_ok) begin
          accept     = 1'b1;
          count_next = CNT_INIT;
          state_next = ST_WAIT;
        end else if (req_any) begin
          // Bad address or both strobes: flag it and stay ready for a retry.
          reject = 1'b1;
        end
      end

      ST_WAIT: begin
        if (count_reg != 4'd0) begin
          count_next = count_reg - 4'd1;
        end else begin
          // Final wait edge: perform the access and announce it next cycle.
          state_next = ST_RESP;
          mem_we     = op_write_reg;
          mem_re     = ~op_write_reg;
        end
      end

      ST_RESP: begin
        // Strobes are deliberately ignored here; the CPU drops them now.
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
        count_next = 4'd0;
      end
    endcase
  end

  // State register, wait counter and the registered AddrError pulse.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_reg      <= ST_IDLE;
      count_reg      <= 4'd0;
      addr_error_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      count_reg      <= count_next;
      addr_error_reg <= reject;
    end
  end

  // Capture address, store data and operation when a request is accepted.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      word_addr_reg <= '0;
      wdata_reg     <= '0;
      op_write_reg  <= 1'b0;
    end else if (accept) begin
      word_addr_reg <= bus.Address[ADDR_WIDTH+1:2];
      wdata_reg     <= bus.WriteData;
      op_write_reg  <= bus.MemWrite;
    end
  end

  // Array write port; a reset on the update edge cancels the pending store.
  always_ff @(posedge Clock) begin
    if (mem_we && !Reset) begin
      mem_array[word_addr_reg] <= wdata_reg;
    end
  end

  // Registered read port; ReadData only moves on read completion or reset.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      rdata_reg <= '0;
    end else if (mem_re) begin
      rdata_reg <= mem_array[word_addr_reg];
    end
  end

  // ---------------------------------------------------------------------
  // Outputs: status decoded straight from the state register
  // ---------------------------------------------------------------------
  assign bus.ReadData  = rdata_reg;
  assign bus.MemBusy   = (state_reg == ST_WAIT);
  assign bus.MemReady  = (state_reg == ST_RESP);
  assign bus.AddrError = addr_error_reg;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder. Two instances are built: one with
// LATENCY=2 (A) and one with LATENCY=0 (B). A single set of bench drivers is
// steered to one instance at a time by sel_b; the other sees idle strobes.
// Expected data comes from a word array per instance plus the last read value;
// expected timing comes from the wait-state arithmetic (accept at edge T,
// MemReady in the cycle after edge T+LATENCY+1, busy for LATENCY+1 cycles).
module tb_mem_responder;

  localparam int AW    = 8;
  localparam int DEPTH = 1 << AW;
  localparam int LAT_A = 2;
  localparam int LAT_B = 0;

  logic        Clock = 1'b0;
  logic        Reset;

  logic        sel_b;
  logic        drv_rd;
  logic        drv_wr;
  logic [31:0] drv_addr;
  logic [31:0] drv_wdata;

  mem_responder_if bus_a ();
  mem_responder_if bus_b ();

  mem_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT_A)) dut_a (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus_a)
  );

  mem_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT_B)) dut_b (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus_b)
  );

  assign bus_a.MemRead   = !sel_b && drv_rd;
  assign bus_a.MemWrite  = !sel_b && drv_wr;
  assign bus_a.Address   = drv_addr;
  assign bus_a.WriteData = drv_wdata;
  assign bus_b.MemRead   = sel_b && drv_rd;
  assign bus_b.MemWrite  = sel_b && drv_wr;
  assign bus_b.Address   = drv_addr;
  assign bus_b.WriteData = drv_wdata;

  logic [31:0] obs_rdata;
  logic        obs_ready;
  logic        obs_busy;
  logic        obs_err;
  assign obs_rdata = sel_b ? bus_b.ReadData  : bus_a.ReadData;
  assign obs_ready = sel_b ? bus_b.MemReady  : bus_a.MemReady;
  assign obs_busy  = sel_b ? bus_b.MemBusy   : bus_a.MemBusy;
  assign obs_err   = sel_b ? bus_b.AddrError : bus_a.AddrError;

  always #5 Clock = ~Clock;

  // Reference model: word contents and last loaded value per instance.
  logic [31:0] model_mem [2][DEPTH];
  logic [31:0] last_rd   [2];

  int vectors     = 0;
  int miscompares = 0;

  function automatic int cur_lat();
    return sel_b ? LAT_B : LAT_A;
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'(a >> 2) % DEPTH;
  endfunction

  // Drive one valid request and follow it to MemReady. While the DUT is busy
  // the bus is overwritten with sa/sd, which must not affect the access.
  task automatic drive_access(input bit rd, input bit wr,
                              input logic [31:0] a, input logic [31:0] d,
                              input logic [31:0] sa, input logic [31:0] sd,
                              output int ready_n, output int busy_n,
                              output int err_n, output logic [31:0] rdata);
    ready_n = 0; busy_n = 0; err_n = 0; rdata = '0;
    drv_rd = rd; drv_wr = wr; drv_addr = a; drv_wdata = d;
    for (int n = 1; n <= 40; n++) begin
      @(negedge Clock);
      if (obs_busy) begin
        busy_n++;
        drv_addr  = sa;
        drv_wdata = sd;
      end
      if (obs_err) err_n++;
      if (obs_ready) begin
        ready_n = n;
        rdata   = obs_rdata;
        break;
      end
    end
    drv_rd = 1'b0; drv_wr = 1'b0;
    @(negedge Clock);
    $display("[%0t] dut=%s %s addr=%08h wdata=%08h -> ready@%0d busy=%0d rdata=%08h",
             $time, sel_b ? "B" : "A", wr ? "WR" : "RD", a, d, ready_n, busy_n, rdata);
  endtask

  // Hold a request that must be rejected for 'hold' cycles, then idle two more.
  task automatic drive_bad(input bit rd, input bit wr, input logic [31:0] a,
                           input int hold, output int err_n, output int busy_n,
                           output int ready_n, output logic [31:0] rdata);
    err_n = 0; busy_n = 0; ready_n = 0;
    drv_rd = rd; drv_wr = wr; drv_addr = a; drv_wdata = $urandom;
    for (int n = 1; n <= hold + 2; n++) begin
      @(negedge Clock);
      if (obs_err)   err_n++;
      if (obs_busy)  busy_n++;
      if (obs_ready) ready_n++;
      if (n == hold) begin
        drv_rd = 1'b0; drv_wr = 1'b0;
      end
    end
    rdata = obs_rdata;
    $display("[%0t] dut=%s BAD rd=%0b wr=%0b addr=%08h hold=%0d -> err=%0d busy=%0d ready=%0d",
             $time, sel_b ? "B" : "A", rd, wr, a, hold, err_n, busy_n, ready_n);
  endtask

  task automatic test_reset();
    Reset = 1'b1; drv_rd = 1'b0; drv_wr = 1'b0; drv_addr = '0; drv_wdata = '0; sel_b = 1'b0;
    repeat (3) @(negedge Clock);
    for (int s = 0; s < 2; s++) begin
      sel_b = s[0];
      #1;
      vectors++;
      if (obs_rdata !== 32'h0) begin miscompares++; $display("FAIL reset_rdata dut=%0d got %08h want 0", s, obs_rdata); end
      vectors++;
      if ({obs_ready, obs_busy, obs_err} !== 3'b000) begin
        miscompares++; $display("FAIL reset_status dut=%0d got rdy/busy/err=%03b want 000", s, {obs_ready, obs_busy, obs_err});
      end
      last_rd[s] = '0;
    end
    sel_b = 1'b0;
    Reset = 1'b0;
    @(negedge Clock);
    $display("[%0t] reset released", $time);
  endtask

  // Give every word a known value so later reads never see uninitialised RAM.
  task automatic test_preload();
    int rn, bn, en;
    logic [31:0] rd, d;
    for (int s = 0; s < 2; s++) begin
      sel_b = s[0];
      for (int w = 0; w < DEPTH; w++) begin
        d = $urandom;
        drive_access(1'b0, 1'b1, 32'(w) << 2, d, $urandom, $urandom, rn, bn, en, rd);
        model_mem[s][w] = d;
        vectors++;
        if (rn !== cur_lat() + 2 || bn !== cur_lat() + 1 || rd !== last_rd[s]) begin
          miscompares++;
          $display("FAIL preload_write dut=%0d word=%0d got ready@%0d busy=%0d rdata=%08h want ready@%0d busy=%0d rdata=%08h",
                   s, w, rn, bn, rd, cur_lat() + 2, cur_lat() + 1, last_rd[s]);
        end
      end
    end
    sel_b = 1'b0;
  endtask

  task automatic test_write_read();
    int rn, bn, en;
    logic [31:0] rd;
    sel_b = 1'b0;
    drive_access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h10, 32'hDEADBEEF, rn, bn, en, rd);
    model_mem[0][4] = 32'hDEADBEEF;
    vectors++;
    if (rn !== 4) begin miscompares++; $display("FAIL wr_ready_delay got %0d want 4", rn); end
    vectors++;
    if (bn !== 3) begin miscompares++; $display("FAIL wr_busy_cycles got %0d want 3", bn); end
    vectors++;
    if (rd !== last_rd[0]) begin miscompares++; $display("FAIL wr_keeps_rdata got %08h want %08h", rd, last_rd[0]); end
    drive_access(1'b1, 1'b0, 32'h10, 32'h0, 32'h10, 32'h0, rn, bn, en, rd);
    last_rd[0] = 32'hDEADBEEF;
    vectors++;
    if (rn !== 4) begin miscompares++; $display("FAIL rd_ready_delay got %0d want 4", rn); end
    vectors++;
    if (bn !== 3) begin miscompares++; $display("FAIL rd_busy_cycles got %0d want 3", bn); end
    vectors++;
    if (rd !== 32'hDEADBEEF) begin miscompares++; $display("FAIL rd_after_wr got %08h want DEADBEEF", rd); end
  endtask

  task automatic test_addr_error();
    int en, bn, rn, h;
    logic [31:0] rd, bad;
    logic [31:0] bad_list [4];
    bad_list[0] = 32'h13; bad_list[1] = 32'h400; bad_list[2] = 32'h12; bad_list[3] = 32'h8000_0010;
    sel_b = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bad = bad_list[i];
      h   = (i == 3) ? 3 : 1;
      drive_bad(i != 2, i == 2, bad, h, en, bn, rn, rd);
      vectors++;
      if (en !== h) begin miscompares++; $display("FAIL addr_err_pulses addr=%08h got %0d want %0d", bad, en, h); end
      vectors++;
      if (bn !== 0 || rn !== 0) begin miscompares++; $display("FAIL addr_err_no_access addr=%08h got busy=%0d ready=%0d want 0 0", bad, bn, rn); end
      vectors++;
      if (rd !== last_rd[0]) begin miscompares++; $display("FAIL addr_err_rdata addr=%08h got %08h want %08h", bad, rd, last_rd[0]); end
    end
    // The rejected store to 0x12 must not have reached word 4.
    drive_access(1'b1, 1'b0, 32'h10, 32'h0, 32'h10, 32'h0, rn, bn, en, rd);
    last_rd[0] = model_mem[0][4];
    vectors++;
    if (rd !== model_mem[0][4]) begin miscompares++; $display("FAIL addr_err_array got %08h want %08h", rd, model_mem[0][4]); end
  endtask

  task automatic test_both_strobes();
    int en, bn, rn;
    logic [31:0] rd;
    sel_b = 1'b0;
    drive_bad(1'b1, 1'b1, 32'h20, 1, en, bn, rn, rd);
    vectors++;
    if (en !== 1 || bn !== 0 || rn !== 0) begin
      miscompares++; $display("FAIL both_strobes got err=%0d busy=%0d ready=%0d want 1 0 0", en, bn, rn);
    end
    drive_access(1'b1, 1'b0, 32'h20, 32'h0, 32'h20, 32'h0, rn, bn, en, rd);
    last_rd[0] = model_mem[0][8];
    vectors++;
    if (rd !== model_mem[0][8]) begin miscompares++; $display("FAIL both_strobes_array got %08h want %08h", rd, model_mem[0][8]); end
  endtask

  task automatic test_input_change();
    int en, bn, rn;
    logic [31:0] rd;
    sel_b = 1'b0;
    drive_access(1'b0, 1'b1, 32'h04, 32'h12345678, 32'h08, 32'hFFFFFFFF, rn, bn, en, rd);
    model_mem[0][1] = 32'h12345678;
    drive_access(1'b1, 1'b0, 32'h04, 32'h0, 32'h08, 32'h0, rn, bn, en, rd);
    last_rd[0] = model_mem[0][1];
    vectors++;
    if (rd !== 32'h12345678) begin miscompares++; $display("FAIL latched_write got %08h want 12345678", rd); end
    drive_access(1'b1, 1'b0, 32'h08, 32'h0, 32'h04, 32'h0, rn, bn, en, rd);
    last_rd[0] = model_mem[0][2];
    vectors++;
    if (rd !== model_mem[0][2]) begin miscompares++; $display("FAIL neighbour_untouched got %08h want %08h", rd, model_mem[0][2]); end
  endtask

  task automatic test_reset_mid();
    int en, bn, rn;
    logic [31:0] rd;
    sel_b = 1'b0;
    drv_wr = 1'b1; drv_addr = 32'h0C; drv_wdata = 32'hAAAA5555;
    @(negedge Clock);          // first WAIT cycle
    @(negedge Clock);          // second WAIT cycle
    vectors++;
    if (obs_busy !== 1'b1) begin miscompares++; $display("FAIL reset_mid_busy got %0b want 1", obs_busy); end
    Reset = 1'b1;
    @(negedge Clock);
    vectors++;
    if ({obs_rdata, obs_ready, obs_busy, obs_err} !== 35'h0) begin
      miscompares++;
      $display("FAIL reset_mid_outputs got rdata=%08h rdy=%0b busy=%0b err=%0b want all 0", obs_rdata, obs_ready, obs_busy, obs_err);
    end
    Reset = 1'b0; drv_wr = 1'b0;
    last_rd[0] = '0; last_rd[1] = '0;
    @(negedge Clock);
    $display("[%0t] reset asserted during write to 0000000c", $time);
    drive_access(1'b1, 1'b0, 32'h0C, 32'h0, 32'h0C, 32'h0, rn, bn, en, rd);
    last_rd[0] = model_mem[0][3];
    vectors++;
    if (rn !== LAT_A + 2) begin miscompares++; $display("FAIL reset_mid_restart got ready@%0d want %0d", rn, LAT_A + 2); end
    vectors++;
    if (rd !== model_mem[0][3]) begin miscompares++; $display("FAIL reset_mid_old_data got %08h want %08h", rd, model_mem[0][3]); end
  endtask

  // LATENCY=0 instance, MemRead held high throughout; one access per 3 cycles.
  task automatic test_back_to_back();
    int k;
    bit exp_busy, exp_ready;
    sel_b = 1'b1;
    drv_rd = 1'b1; drv_wr = 1'b0; drv_addr = 32'h00;
    for (int n = 1; n <= 6; n++) begin
      @(negedge Clock);
      k = (n - 1) % (LAT_B + 3);
      exp_busy  = (k <= LAT_B);
      exp_ready = (k == LAT_B + 1);
      vectors++;
      if (obs_busy !== exp_busy) begin miscompares++; $display("FAIL b2b_busy cycle=%0d got %0b want %0b", n, obs_busy, exp_busy); end
      vectors++;
      if (obs_ready !== exp_ready) begin miscompares++; $display("FAIL b2b_ready cycle=%0d got %0b want %0b", n, obs_ready, exp_ready); end
      if (n == 2) begin
        vectors++;
        if (obs_rdata !== model_mem[1][0]) begin miscompares++; $display("FAIL b2b_rdata0 got %08h want %08h", obs_rdata, model_mem[1][0]); end
        $display("[%0t] dut=B RD addr=00000000 back-to-back rdata=%08h", $time, obs_rdata);
        drv_addr = 32'h04;
      end
      if (n == 5) begin
        vectors++;
        if (obs_rdata !== model_mem[1][1]) begin miscompares++; $display("FAIL b2b_rdata1 got %08h want %08h", obs_rdata, model_mem[1][1]); end
        $display("[%0t] dut=B RD addr=00000004 back-to-back rdata=%08h", $time, obs_rdata);
        drv_rd = 1'b0;
      end
    end
    last_rd[1] = model_mem[1][1];
    sel_b = 1'b0;
  endtask

  task automatic test_random();
    int en, bn, rn, kind, s, w, h;
    logic [31:0] rd, a, d, exp;
    for (int i = 0; i < 80; i++) begin
      s = int'($urandom_range(0, 1));
      sel_b = s[0];
      kind = int'($urandom_range(0, 9));
      w = int'($urandom_range(0, DEPTH - 1));
      a = 32'(w) << 2;
      d = $urandom;
      if (kind <= 7) begin
        drive_access(kind >= 4, kind < 4, a, d, $urandom, $urandom, rn, bn, en, rd);
        if (kind < 4) begin
          model_mem[s][w] = d;
          exp = last_rd[s];
        end else begin
          exp = model_mem[s][w];
          last_rd[s] = exp;
        end
        vectors++;
        if (rn !== cur_lat() + 2) begin miscompares++; $display("FAIL rnd_ready dut=%0d addr=%08h got %0d want %0d", s, a, rn, cur_lat() + 2); end
        vectors++;
        if (bn !== cur_lat() + 1) begin miscompares++; $display("FAIL rnd_busy dut=%0d addr=%08h got %0d want %0d", s, a, bn, cur_lat() + 1); end
        vectors++;
        if (en !== 0) begin miscompares++; $display("FAIL rnd_no_err dut=%0d addr=%08h got %0d want 0", s, a, en); end
        vectors++;
        if (rd !== exp) begin miscompares++; $display("FAIL rnd_rdata dut=%0d addr=%08h got %08h want %08h", s, a, rd, exp); end
      end else begin
        if (kind == 8) begin
          if ($urandom_range(0, 1) == 1) a = a | 32'($urandom_range(1, 3));
          else a = a | (32'h400 << $urandom_range(0, 21));
        end
        h = int'($urandom_range(1, 2));
        drive_bad(kind == 9 || d[0], kind == 9 || !d[0], a, h, en, bn, rn, rd);
        vectors++;
        if (en !== h || bn !== 0 || rn !== 0) begin
          miscompares++; $display("FAIL rnd_reject dut=%0d addr=%08h got err=%0d busy=%0d ready=%0d want %0d 0 0", s, a, en, bn, rn, h);
        end
        vectors++;
        if (rd !== last_rd[s]) begin miscompares++; $display("FAIL rnd_reject_rdata dut=%0d got %08h want %08h", s, rd, last_rd[s]); end
      end
    end
    sel_b = 1'b0;
  endtask

  initial begin
    test_reset();
    test_preload();
    test_write_read();
    test_addr_error();
    test_both_strobes();
    test_input_change();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish, vectors=%0d", vectors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Word-addressed data/instruction memory responder serving the multicycle CPU's memory strobes (MemRead/MemWrite) with a configurable wait-state latency and a one-cycle MemReady completion pulse.
- Sits on the memory side of the CPU memory interface, opposite the control FSM that raises the strobes.
- Misaligned or out-of-range accesses are flagged on AddrError, which feeds the CPU's cause/EPC logic.

Parameters:
- ADDR_WIDTH, 8, log2 of the memory depth in 32-bit words (256 words).
- LATENCY, 2, wait cycles inserted before completion (0..15).

Ports:
- Clock  input  1  rising-edge clock
- Reset  input  1  synchronous, active-high reset
- MemRead  input  1  read strobe, held by the CPU until MemReady
- MemWrite  input  1  write strobe, held by the CPU until MemReady
- Address  input  32  byte address
- WriteData  input  32  store data
- ReadData  output  32  registered load data
- MemReady  output  1  one-cycle completion pulse
- MemBusy  output  1  high while an access is pending
- AddrError  output  1  one-cycle pulse for a rejected request

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - Reset is synchronous and active-high, sampled on the rising edge of Clock.
  - Reset values: ReadData=0, MemReady=0, MemBusy=0, AddrError=0, state=IDLE, counter=0. The array is not cleared.
- Storage: 2^ADDR_WIDTH x 32-bit words, indexed by Address[ADDR_WIDTH+1:2].
- States: IDLE, WAIT, RESP.
- IDLE, at each edge:
  - If exactly one strobe is high and the address is valid: latch address, data and op; load counter=LATENCY; go to WAIT.
  - Valid address means Address[1:0]==0 and Address[31:ADDR_WIDTH+2]==0.
  - If a strobe is high and the address is invalid, or both strobes are high: AddrError=1 for the next cycle, no array access, stay in IDLE. If the CPU keeps the bad request asserted, AddrError stays high each cycle.
  - No strobe: stay in IDLE.
- WAIT:
  - MemBusy=1.
  - At each edge, if counter!=0, decrement it.
  - If counter==0: go to RESP. On that same edge a write updates the array, or a read loads ReadData from the latched address.
- RESP:
  - MemReady=1 and MemBusy=0 for exactly one cycle.
  - Strobes are ignored in this cycle; the CPU must drop or change them here.
  - Next edge returns to IDLE.
- Timing: for a request sampled at edge T, MemReady is high in the cycle following edge T+LATENCY+1.
  - LATENCY=2: MemReady visible 3 cycles after acceptance.
  - LATENCY=0: 1 cycle after acceptance.
  - Back-to-back throughput: one access per LATENCY+3 cycles.
- Inputs during an access: strobe, Address and WriteData changes during WAIT/RESP have no effect; latched values are used.
- ReadData holds its last read value. It changes only on read completion or reset, and writes never alter it.
- Read-after-write to the same word returns the newly written data.
- Reset mid-operation: abort to IDLE with outputs cleared. A pending write is not performed unless its array-update edge has already occurred.
- Address wrap: none. Out-of-range addresses are errors, never aliased.

Test Plan:
- Reset, then write 0xDEADBEEF to 0x00000010 (LATENCY=2), then read 0x10 → MemReady 3 cycles after each accept; ReadData=0xDEADBEEF; MemBusy high for exactly 3 cycles per access.
- Read 0x00000013 (misaligned) and read 0x00000400 (out of range, ADDR_WIDTH=8) → AddrError pulses one cycle each; no MemReady; MemBusy stays 0; array and ReadData unchanged.
- Assert MemRead and MemWrite together at 0x20 → AddrError=1, no access; then a read of 0x20 returns its previous value.
- Write 0x12345678 at 0x04, changing Address to 0x08 and WriteData to 0xFFFFFFFF during WAIT → word 0x04 reads 0x12345678; word 0x08 unchanged.
- Start a write of 0xAAAA5555 to 0x0C, assert Reset in the 2nd WAIT cycle → all outputs 0, state IDLE; a subsequent read of 0x0C returns the old contents.
- LATENCY=0 instance: back-to-back reads of 0x00 and 0x04 with strobes kept high through RESP → MemReady pulses exactly 1 cycle after each accept; the RESP-cycle strobe is ignored; next accept occurs the edge after RESP.
